// File: rtl/codec_i2c_pkg.sv
// ============================================================================
// codec_i2c_pkg : shared types, register map and reset defaults for the
//                 WM8731-style I2C control-port target.  Rev 1.0
// ============================================================================
`default_nettype none

package codec_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_ACK_A  = 3'd2,
    ST_BYTE2  = 3'd3,
    ST_ACK_2  = 3'd4,
    ST_BYTE3  = 3'd5,
    ST_ACK_3  = 3'd6,
    ST_IGNORE = 3'd7
  } state_e;

  localparam logic [6:0]  DEFAULT_DEV_ADDR = 7'h1A;
  localparam int          NUM_CODEC_REGS   = 10;

  localparam logic [6:0] REG_LIN_L  = 7'd0;
  localparam logic [6:0] REG_RIN_L  = 7'd1;
  localparam logic [6:0] REG_LHP    = 7'd2;
  localparam logic [6:0] REG_RHP    = 7'd3;
  localparam logic [6:0] REG_AAPC   = 7'd4;
  localparam logic [6:0] REG_DAPC   = 7'd5;
  localparam logic [6:0] REG_PDC    = 7'd6;
  localparam logic [6:0] REG_DAIF   = 7'd7;
  localparam logic [6:0] REG_SRC    = 7'd8;
  localparam logic [6:0] REG_ACTIVE = 7'd9;
  localparam logic [6:0] REG_RESET  = 7'h0F;

  localparam logic [8:0] REG_DEFAULTS [NUM_CODEC_REGS] = '{
    9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
    9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
  };

  // Indices beyond the codec's own map default to zero.
  function automatic logic [8:0] reg_default(input int idx);
    if (idx >= 0 && idx < NUM_CODEC_REGS) return REG_DEFAULTS[idx[3:0]];
    return 9'h000;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
// ============================================================================
// i2c_bus_sync : 2-flop synchronisers plus history flop on SCL/SDA, with
//                SCL edge and START/STOP condition detection.  Rev 1.0
// ============================================================================
`default_nettype none

module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  // Idle bus is high, so resetting to 1 avoids a spurious edge at release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
    end
  end

  assign scl_rise  =  scl_sync_q & ~scl_hist_q;
  assign scl_fall  = ~scl_sync_q &  scl_hist_q;
  assign start_det =  scl_sync_q &  scl_hist_q & ~sda_sync_q &  sda_hist_q;
  assign stop_det  =  scl_sync_q &  scl_hist_q &  sda_sync_q & ~sda_hist_q;
  assign sda_s     =  sda_sync_q;

endmodule

`default_nettype wire

// File: rtl/i2c_codec_target.sv
// ============================================================================
// i2c_codec_target : write-only I2C target modelling the WM8731 control port,
//                    with a 9-bit shadow register file and write strobe. Rev 1.0
// ============================================================================
`default_nettype none

module i2c_codec_target
  import codec_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEFAULT_DEV_ADDR,
  parameter int         NUM_REGS  = NUM_CODEC_REGS,
  parameter logic [6:0] RESET_REG = REG_RESET
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [6:0] wr_reg,
  output logic [8:0] wr_data,
  output logic       bad_reg,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_e     state_q,    state_d;
  logic [3:0] cnt_q,      cnt_d;
  logic [7:0] sr_q,       sr_d;
  logic [6:0] reg_q,      reg_d;
  logic       d8_q,       d8_d;
  logic       sda_oe_q,   sda_oe_d;
  logic       busy_q,     busy_d;
  logic       wr_valid_q, wr_valid_d;
  logic       bad_reg_q,  bad_reg_d;
  logic [6:0] wr_reg_q,   wr_reg_d;
  logic [8:0] wr_data_q,  wr_data_d;
  logic [8:0] regs_q [NUM_REGS];
  logic [8:0] regs_d [NUM_REGS];
  logic [8:0] w_wdata;

  assign w_wdata = {d8_q, sr_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    reg_d      = reg_q;
    d8_d       = d8_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    bad_reg_d  = 1'b0;
    wr_reg_d   = wr_reg_q;
    wr_data_d  = wr_data_q;
    regs_d     = regs_q;

    if (stop_det) begin
      state_d  = ST_IDLE;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = 4'd0;
      sr_d     = 8'h00;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR, ST_BYTE2, ST_BYTE3: begin
          if (scl_rise && cnt_q < 4'd8) begin
            sr_d  = {sr_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (state_q == ST_ADDR) begin
              if (sr_q == {DEV_ADDR, 1'b0}) begin
                state_d  = ST_ACK_A;
                sda_oe_d = 1'b1;
              end else begin
                state_d  = ST_IGNORE;
              end
            end else if (state_q == ST_BYTE2) begin
              reg_d    = sr_q[7:1];
              d8_d     = sr_q[0];
              state_d  = ST_ACK_2;
              sda_oe_d = 1'b1;
            end else begin
              state_d  = ST_ACK_3;
              sda_oe_d = 1'b1;
              if (reg_q < 7'(NUM_REGS)) begin
                for (int i = 0; i < NUM_REGS; i++)
                  if (reg_q == 7'(i)) regs_d[i] = w_wdata;
                wr_valid_d = 1'b1;
                wr_reg_d   = reg_q;
                wr_data_d  = w_wdata;
              end else if (reg_q == RESET_REG) begin
                for (int i = 0; i < NUM_REGS; i++) regs_d[i] = reg_default(i);
                wr_valid_d = 1'b1;
                wr_reg_d   = reg_q;
                wr_data_d  = w_wdata;
              end else begin
                bad_reg_d  = 1'b1;
              end
            end
          end
        end
        ST_ACK_A, ST_ACK_2, ST_ACK_3: begin
          // Hold the ACK through the 9th SCL high phase; release on its fall.
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = (state_q == ST_ACK_A) ? ST_BYTE2 :
                       (state_q == ST_ACK_2) ? ST_BYTE3 : ST_IGNORE;
          end
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      sr_q       <= 8'h00;
      reg_q      <= 7'h00;
      d8_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      bad_reg_q  <= 1'b0;
      wr_reg_q   <= 7'h00;
      wr_data_q  <= 9'h000;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_default(i);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      reg_q      <= reg_d;
      d8_q       <= d8_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      bad_reg_q  <= bad_reg_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
      regs_q     <= regs_d;
    end
  end

  always_comb begin
    rd_data = 9'h000;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_addr == 4'(i)) rd_data = regs_q[i];
  end

  assign sda_oe   = sda_oe_q;
  assign wr_valid = wr_valid_q;
  assign wr_reg   = wr_reg_q;
  assign wr_data  = wr_data_q;
  assign bad_reg  = bad_reg_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_codec_target.sv
// ============================================================================
// tb_i2c_codec_target : directed I2C write transactions against the codec
//                       control-port target, with a shadow register model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2c_codec_target;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic [3:0] rd_addr = 4'd0;
  logic       sda_oe, wr_valid, bad_reg, busy;
  logic [6:0] wr_reg;
  logic [8:0] wr_data, rd_data;
  logic       sda_line;

  assign sda_line = sda_oe ? 1'b0 : sda_m;

  i2c_codec_target dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .wr_valid (wr_valid),
    .wr_reg   (wr_reg),
    .wr_data  (wr_data),
    .bad_reg  (bad_reg),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  int bad_cnt = 0;

  always @(posedge clk) begin
    if (wr_valid) wr_cnt <= wr_cnt + 1;
    if (bad_reg)  bad_cnt <= bad_cnt + 1;
  end

  logic [8:0] dflt [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                           9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
  logic [8:0] exp_regs [10];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait();
    scl   = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl   = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    scl   = 1'b1; qwait();
    sda_m = 1'b1; qwait();
  endtask

  // SDA low on the 9th SCL high phase means ACK.
  task automatic send_byte(input logic [7:0] b, input bit exp_ack, input string tag);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; qwait();
      scl = 1'b1; qwait(); qwait();
      scl = 1'b0; qwait();
    end
    sda_m = 1'b1; qwait();
    scl = 1'b1; qwait();
    chk(tag, 32'(sda_line), exp_ack ? 32'd0 : 32'd1);
    qwait();
    scl = 1'b0; qwait();
  endtask

  task automatic write3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input string tag);
    i2c_start();
    send_byte(a, 1'b1, {tag, "_ack1"});
    send_byte(b, 1'b1, {tag, "_ack2"});
    send_byte(c, 1'b1, {tag, "_ack3"});
    i2c_stop();
    qwait();
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 10; i++) begin
      rd_addr = 4'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), 32'(rd_data), 32'(exp_regs[i]));
    end
  endtask

  task automatic check_one(input int idx, input string tag);
    rd_addr = 4'(idx);
    #1;
    chk(tag, 32'(rd_data), 32'(exp_regs[idx]));
  endtask

  initial begin
    for (int i = 0; i < 10; i++) exp_regs[i] = dflt[i];
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    qwait();

    // Reset state
    check_regs("rst");
    rd_addr = 4'd12; #1;
    chk("rst_rd_oob", 32'(rd_data), 32'h0);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_reg", 32'(wr_reg), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);

    // Basic write: reg 7 <= 0x041
    i2c_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    send_byte(8'h34, 1'b1, "w7_ack1");
    send_byte(8'h0E, 1'b1, "w7_ack2");
    send_byte(8'h41, 1'b1, "w7_ack3");
    i2c_stop();
    qwait();
    exp_regs[7] = 9'h041;
    chk("w7_busy_after_stop", 32'(busy), 32'd0);
    chk("w7_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("w7_wr_reg", 32'(wr_reg), 32'h07);
    chk("w7_wr_data", 32'(wr_data), 32'h041);
    check_one(7, "w7_rd7");

    // reg 0 <= 0x1FD (data bit 8 via byte 2), then reg 9 <= 0x001
    write3(8'h34, 8'h01, 8'hFD, "w0");
    exp_regs[0] = 9'h1FD;
    check_one(0, "w0_rd0");
    chk("w0_wr_data", 32'(wr_data), 32'h1FD);
    write3(8'h34, 8'h12, 8'h01, "w9");
    exp_regs[9] = 9'h001;
    check_one(9, "w9_rd9");
    check_one(0, "w9_rd0_kept");
    chk("w9_wr_cnt", 32'(wr_cnt), 32'd3);

    // Wrong address and read request are NACKed and ignored until STOP
    i2c_start();
    send_byte(8'h36, 1'b0, "addr36_nack");
    send_byte(8'h0E, 1'b0, "addr36_b2_nack");
    i2c_stop();
    i2c_start();
    send_byte(8'h35, 1'b0, "addr35_nack");
    i2c_stop();
    qwait();
    chk("nack_wr_cnt", 32'(wr_cnt), 32'd3);
    chk("nack_busy", 32'(busy), 32'd0);
    write3(8'h34, 8'h0A, 8'h12, "w5");
    exp_regs[5] = 9'h012;
    check_one(5, "w5_rd5");
    chk("w5_wr_cnt", 32'(wr_cnt), 32'd4);

    // Modify R4, then RESET_REG write restores all defaults
    write3(8'h34, 8'h09, 8'hFF, "w4");
    exp_regs[4] = 9'h1FF;
    check_one(4, "w4_rd4");
    write3(8'h34, 8'h1E, 8'h00, "wrst");
    for (int i = 0; i < 10; i++) exp_regs[i] = dflt[i];
    check_regs("wrst");
    chk("wrst_wr_cnt", 32'(wr_cnt), 32'd6);
    chk("wrst_wr_reg", 32'(wr_reg), 32'h0F);
    chk("wrst_wr_data", 32'(wr_data), 32'h000);

    // Partial transaction ended by STOP
    i2c_start();
    send_byte(8'h34, 1'b1, "pstop_ack1");
    send_byte(8'h0E, 1'b1, "pstop_ack2");
    i2c_stop();
    qwait();
    chk("pstop_wr_cnt", 32'(wr_cnt), 32'd6);
    check_one(7, "pstop_rd7");

    // Partial transaction ended by repeated START, then a full write
    i2c_start();
    send_byte(8'h34, 1'b1, "prs_ack1");
    send_byte(8'h0E, 1'b1, "prs_ack2");
    i2c_start();
    send_byte(8'h34, 1'b1, "prs_ack3");
    send_byte(8'h06, 1'b1, "prs_ack4");
    send_byte(8'h55, 1'b1, "prs_ack5");
    i2c_stop();
    qwait();
    exp_regs[3] = 9'h055;
    check_one(7, "prs_rd7");
    check_one(3, "prs_rd3");
    chk("prs_wr_cnt", 32'(wr_cnt), 32'd7);

    // Unimplemented register 0x10: ACKed, bad_reg pulse, no change
    write3(8'h34, 8'h20, 8'h55, "wbad");
    chk("wbad_bad_cnt", 32'(bad_cnt), 32'd1);
    chk("wbad_wr_cnt", 32'(wr_cnt), 32'd7);
    check_regs("wbad");

    // Fourth byte is NACKed, no auto-increment
    i2c_start();
    send_byte(8'h34, 1'b1, "w8_ack1");
    send_byte(8'h10, 1'b1, "w8_ack2");
    send_byte(8'h03, 1'b1, "w8_ack3");
    send_byte(8'h77, 1'b0, "w8_b4_nack");
    i2c_stop();
    qwait();
    exp_regs[8] = 9'h003;
    check_one(8, "w8_rd8");
    check_one(9, "w8_rd9");
    chk("w8_wr_cnt", 32'(wr_cnt), 32'd8);
    chk("w8_wr_reg", 32'(wr_reg), 32'h08);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
